// File: rtl/pipeline_pkg.sv
// Shared types, widths and parameter defaults for the pipeline hazard/stop controller.
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W      = 5;
  localparam int unsigned STALL_CNT_W     = 32;
  localparam int unsigned MDU_TIMEOUT_DEF = 40;
  localparam int unsigned STOP_DRAIN_DEF  = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MDU_WAIT = 2'b01,
    ST_DRAIN    = 2'b10,
    ST_HALT     = 2'b11
  } state_e;

  // Destination-write info of the instruction currently in EX.
  typedef struct packed {
    logic                  mem_to_reg;
    logic                  rd_we;
    logic [REG_ADDR_W-1:0] rd_addr;
  } ex_wr_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: EX load writing a register that ID is about to read.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic                  i_rs1_in_use,
  input  logic                  i_rs2_in_use,
  input  ex_wr_t                i_ex_wr,
  output logic                  o_load_use_c
);

  logic w_ld_valid;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign w_ld_valid   = i_ex_wr.mem_to_reg & i_ex_wr.rd_we & (i_ex_wr.rd_addr != '0);
  assign w_rs1_hit    = i_rs1_in_use & (i_rs1_addr == i_ex_wr.rd_addr);
  assign w_rs2_hit    = i_rs2_in_use & (i_rs2_addr == i_ex_wr.rd_addr);
  assign o_load_use_c = w_ld_valid & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control FSM: load-use stall, branch flush, iterative-divider wait and stop/drain/halt.
// Optional stall-cycle performance counter enabled by defining PIPE_PERF_CNT_EN.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MDU_TIMEOUT = MDU_TIMEOUT_DEF,
  parameter int unsigned STOP_DRAIN  = STOP_DRAIN_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_ADDR_W-1:0]  id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0]  id_rs2_addr_i,
  input  logic                   id_rs1_in_use_i,
  input  logic                   id_rs2_in_use_i,
  input  logic                   id_stop_flag_i,
  input  logic                   ex_mem_to_reg_i,
  input  logic                   ex_rd_we_i,
  input  logic [REG_ADDR_W-1:0]  ex_rd_addr_i,
  input  logic                   ex_branch_taken_i,
  input  logic                   ex_mdu_req_i,
  input  logic                   mdu_done_i,
  output logic                   mdu_start_o,
  output logic                   pc_en_o,
  output logic                   if_id_en_o,
  output logic                   if_id_flush_o,
  output logic                   id_ex_flush_o,
  output logic                   ex_hold_o,
  output logic                   halted_o,
  output logic                   mdu_err_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned CNT_W = $clog2(max_u(MDU_TIMEOUT, STOP_DRAIN) + 1);
  localparam logic [CNT_W-1:0] MDU_LAST   = CNT_W'(MDU_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(STOP_DRAIN - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_mdu_err;
  logic             w_mdu_err_set;
  logic             w_load_use;
  ex_wr_t           w_ex_wr;

  assign w_ex_wr.mem_to_reg = ex_mem_to_reg_i;
  assign w_ex_wr.rd_we      = ex_rd_we_i;
  assign w_ex_wr.rd_addr    = ex_rd_addr_i;

  hazard_detect u_hazard_detect (
    .i_rs1_addr   (id_rs1_addr_i),
    .i_rs2_addr   (id_rs2_addr_i),
    .i_rs1_in_use (id_rs1_in_use_i),
    .i_rs2_in_use (id_rs2_in_use_i),
    .i_ex_wr      (w_ex_wr),
    .o_load_use_c (w_load_use)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shared wait/drain counter; RUN keeps it at zero so both waits start from a clean count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_mdu_err <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_mdu_err <= r_mdu_err | w_mdu_err_set;
    end
  end

  // Outputs are forced to the RUN idle pattern while reset is held low.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_mdu_err_set = 1'b0;
    mdu_start_o   = 1'b0;
    pc_en_o       = 1'b1;
    if_id_en_o    = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    ex_hold_o     = 1'b0;
    halted_o      = 1'b0;
    if (reset) begin
      case (r_state)
        ST_RUN: begin
          w_cnt_nxt = '0;
          if (ex_branch_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end else if (ex_mdu_req_i) begin
            mdu_start_o = 1'b1;
            ex_hold_o   = 1'b1;
            pc_en_o     = 1'b0;
            if_id_en_o  = 1'b0;
            w_state_nxt = ST_MDU_WAIT;
          end else if (id_stop_flag_i) begin
            w_state_nxt = ST_DRAIN;
          end else if (w_load_use) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
          end
        end
        ST_MDU_WAIT: begin
          if (mdu_done_i) begin
            w_state_nxt = ST_RUN;
          end else begin
            ex_hold_o  = 1'b1;
            pc_en_o    = 1'b0;
            if_id_en_o = 1'b0;
            if (r_cnt == MDU_LAST) begin
              w_mdu_err_set = 1'b1;
              w_state_nxt   = ST_HALT;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          pc_en_o       = 1'b0;
          if_id_flush_o = 1'b1;
          if (r_cnt == DRAIN_LAST) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_HALT: begin
          pc_en_o    = 1'b0;
          if_id_en_o = 1'b0;
          halted_o   = 1'b1;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  assign mdu_err_o = r_mdu_err;

`ifdef PIPE_PERF_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_stall;

  assign w_stall = (r_state != ST_HALT) & ~pc_en_o;

  // Saturating count of frozen-PC cycles outside HALT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a table of single-cycle RUN vectors plus multi-cycle sequences.
module tb_pipeline_ctrl;

  localparam int unsigned T_MDU   = 40;
  localparam int unsigned T_DRAIN = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic        id_rs1_in_use_i, id_rs2_in_use_i, id_stop_flag_i;
  logic        ex_mem_to_reg_i, ex_rd_we_i, ex_branch_taken_i, ex_mdu_req_i, mdu_done_i;
  logic        mdu_start_o, pc_en_o, if_id_en_o, if_id_flush_o, id_ex_flush_o;
  logic        ex_hold_o, halted_o, mdu_err_o;
  logic [31:0] stall_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  pipeline_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .id_rs1_addr_i     (id_rs1_addr_i),
    .id_rs2_addr_i     (id_rs2_addr_i),
    .id_rs1_in_use_i   (id_rs1_in_use_i),
    .id_rs2_in_use_i   (id_rs2_in_use_i),
    .id_stop_flag_i    (id_stop_flag_i),
    .ex_mem_to_reg_i   (ex_mem_to_reg_i),
    .ex_rd_we_i        (ex_rd_we_i),
    .ex_rd_addr_i      (ex_rd_addr_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .ex_mdu_req_i      (ex_mdu_req_i),
    .mdu_done_i        (mdu_done_i),
    .mdu_start_o       (mdu_start_o),
    .pc_en_o           (pc_en_o),
    .if_id_en_o        (if_id_en_o),
    .if_id_flush_o     (if_id_flush_o),
    .id_ex_flush_o     (id_ex_flush_o),
    .ex_hold_o         (ex_hold_o),
    .halted_o          (halted_o),
    .mdu_err_o         (mdu_err_o),
    .stall_cnt_o       (stall_cnt_o)
  );

  always #5 clk = ~clk;

  // Output vector order: {start, pc_en, if_id_en, if_id_flush, id_ex_flush, ex_hold, halted}
  localparam logic [6:0] E_IDLE  = 7'b0110000;
  localparam logic [6:0] E_LU    = 7'b0000100;
  localparam logic [6:0] E_BR    = 7'b0111100;
  localparam logic [6:0] E_START = 7'b1000010;
  localparam logic [6:0] E_HOLD  = 7'b0000010;
  localparam logic [6:0] E_DRAIN = 7'b0011000;
  localparam logic [6:0] E_HALT  = 7'b0000001;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2, stop, m2r, we;
    logic [4:0] rd;
    logic       br, mdu;
    logic [6:0] exp;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic stop,
                              input logic m2r, input logic we, input logic [4:0] rd,
                              input logic br, input logic mdu, input logic [6:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.stop = stop;
    v.m2r = m2r; v.we = we; v.rd = rd; v.br = br; v.mdu = mdu; v.exp = exp;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {mdu_start_o, pc_en_o, if_id_en_o, if_id_flush_o, id_ex_flush_o, ex_hold_o, halted_o};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs1_addr_i = '0; id_rs2_addr_i = '0; ex_rd_addr_i = '0;
    id_rs1_in_use_i = 0; id_rs2_in_use_i = 0; id_stop_flag_i = 0;
    ex_mem_to_reg_i = 0; ex_rd_we_i = 0; ex_branch_taken_i = 0;
    ex_mdu_req_i = 0; mdu_done_i = 0;
  endtask

  task automatic set_load_use();
    id_rs1_addr_i = 5'd5; id_rs1_in_use_i = 1; ex_mem_to_reg_i = 1; ex_rd_we_i = 1; ex_rd_addr_i = 5'd5;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle_inputs();
    reset = 0;
    #1 reset = 1;
  endtask

  task automatic mdu_seq(input int done_at);
    int         starts = 0;
    logic [6:0] e;
    logic [31:0] stall_exp;
    pulse_reset();
    for (int cyc = 1; cyc <= 44; cyc++) begin
      @(negedge clk);
      ex_mdu_req_i = (done_at == 0) ? 1'b1 : (cyc <= done_at);
      mdu_done_i   = (cyc == done_at) || (done_at == 0 && cyc == 43);
      #1;
      if (mdu_start_o) starts++;
      if (done_at != 0)
        e = (cyc < done_at) ? ((cyc == 1) ? E_START : E_HOLD) : E_IDLE;
      else
        e = (cyc <= 1 + T_MDU) ? ((cyc == 1) ? E_START : E_HOLD) : E_HALT;
      check($sformatf("mdu%0d_c%0d", done_at, cyc), 32'(outs()), 32'(e));
    end
    check($sformatf("mdu%0d_starts", done_at), 32'(starts), 32'd1);
    check($sformatf("mdu%0d_err", done_at), 32'(mdu_err_o), (done_at == 0) ? 32'd1 : 32'd0);
`ifdef PIPE_PERF_CNT_EN
    stall_exp = (done_at != 0) ? 32'(done_at - 1) : 32'(1 + T_MDU);
`else
    stall_exp = 32'd0;
`endif
    check($sformatf("mdu%0d_stall", done_at), stall_cnt_o, stall_exp);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  e;
    logic [31:0] stall_exp;
    int          starts;
    int          halts;

    vt[0]  = mk(5'd0,  5'd0, 0, 0, 0, 0, 0, 5'd0,  0, 0, E_IDLE);
    vt[1]  = mk(5'd5,  5'd1, 1, 1, 0, 1, 1, 5'd5,  0, 0, E_LU);
    vt[2]  = mk(5'd1,  5'd5, 1, 1, 0, 1, 1, 5'd5,  0, 0, E_LU);
    vt[3]  = mk(5'd0,  5'd1, 1, 1, 0, 1, 1, 5'd0,  0, 0, E_IDLE);
    vt[4]  = mk(5'd5,  5'd2, 0, 1, 0, 1, 1, 5'd5,  0, 0, E_IDLE);
    vt[5]  = mk(5'd5,  5'd1, 1, 1, 0, 0, 1, 5'd5,  0, 0, E_IDLE);
    vt[6]  = mk(5'd5,  5'd1, 1, 1, 0, 1, 0, 5'd5,  0, 0, E_IDLE);
    vt[7]  = mk(5'd5,  5'd1, 1, 1, 0, 1, 1, 5'd5,  1, 0, E_BR);
    vt[8]  = mk(5'd0,  5'd0, 0, 0, 1, 0, 0, 5'd0,  1, 0, E_BR);
    vt[9]  = mk(5'd0,  5'd0, 0, 0, 0, 0, 0, 5'd0,  1, 1, E_BR);
    vt[10] = mk(5'd0,  5'd0, 0, 0, 0, 0, 0, 5'd0,  0, 1, E_START);
    vt[11] = mk(5'd0,  5'd0, 0, 0, 1, 0, 0, 5'd0,  0, 1, E_START);
    vt[12] = mk(5'd5,  5'd1, 1, 1, 0, 1, 1, 5'd5,  0, 1, E_START);
    vt[13] = mk(5'd0,  5'd0, 0, 0, 1, 0, 0, 5'd0,  0, 0, E_IDLE);
    vt[14] = mk(5'd5,  5'd1, 1, 1, 1, 1, 1, 5'd5,  0, 0, E_IDLE);
    vt[15] = mk(5'd1,  5'd5, 1, 0, 0, 1, 1, 5'd5,  0, 0, E_IDLE);
    vt[16] = mk(5'd31, 5'd0, 1, 0, 0, 1, 1, 5'd31, 0, 0, E_LU);

    idle_inputs();
    reset = 0;
    #12;
    check("rst_low_outs", 32'(outs()), 32'(E_IDLE));
    check("rst_low_err", 32'(mdu_err_o), 32'd0);
    check("rst_low_stall", stall_cnt_o, 32'd0);
    @(negedge clk);
    reset = 1;

    // Single-cycle RUN decisions; each vector starts from a fresh reset and is withdrawn before the edge.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      reset = 0;
      #1 reset = 1;
      id_rs1_addr_i = vt[i].rs1; id_rs2_addr_i = vt[i].rs2;
      id_rs1_in_use_i = vt[i].u1; id_rs2_in_use_i = vt[i].u2;
      id_stop_flag_i = vt[i].stop; ex_mem_to_reg_i = vt[i].m2r; ex_rd_we_i = vt[i].we;
      ex_rd_addr_i = vt[i].rd; ex_branch_taken_i = vt[i].br; ex_mdu_req_i = vt[i].mdu;
      #1;
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vt[i].exp));
      #1 idle_inputs();
    end

    mdu_seq(2);
    mdu_seq(34);
    mdu_seq(1 + T_MDU);
    mdu_seq(0);

    // Stop: one detect cycle, drain with a divider request that must be ignored, then halt.
    pulse_reset();
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      id_stop_flag_i = (cyc == 1);
      ex_mdu_req_i   = (cyc >= 2);
      #1;
      e = (cyc == 1) ? E_IDLE : (cyc <= 1 + T_DRAIN) ? E_DRAIN : E_HALT;
      check($sformatf("stop_c%0d", cyc), 32'(outs()), 32'(e));
    end
`ifdef PIPE_PERF_CNT_EN
    stall_exp = 32'(T_DRAIN);
`else
    stall_exp = 32'd0;
`endif
    check("stop_stall", stall_cnt_o, stall_exp);
    check("stop_err", 32'(mdu_err_o), 32'd0);
    @(negedge clk);
    reset = 0;
    #1;
    check("stop_rst_low", 32'(outs()), 32'(E_IDLE));
    check("stop_rst_stall", stall_cnt_o, 32'd0);
    reset = 1;
    idle_inputs();
    #1;
    check("stop_after_rst", 32'(outs()), 32'(E_IDLE));

    // Branch and stop together: the stop is on the wrong path and must not start a drain.
    @(negedge clk);
    ex_branch_taken_i = 1; id_stop_flag_i = 1;
    #1;
    check("brstop_c1", 32'(outs()), 32'(E_BR));
    for (int cyc = 2; cyc <= 5; cyc++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      check($sformatf("brstop_c%0d", cyc), 32'(outs()), 32'(E_IDLE));
    end

    // Reset in the middle of a divider wait (a==0) or a drain (a==1) aborts it cleanly.
    for (int a = 0; a < 2; a++) begin
      pulse_reset();
      for (int cyc = 1; cyc <= 5; cyc++) begin
        @(negedge clk);
        if (a == 0) ex_mdu_req_i = 1;
        else        id_stop_flag_i = (cyc == 1);
      end
      set_load_use();
      reset = 0;
      #1;
      check($sformatf("abort%0d_rst_low", a), 32'(outs()), 32'(E_IDLE));
      reset = 1;
      idle_inputs();
      starts = 0;
      halts  = 0;
      for (int cyc = 0; cyc < 45; cyc++) begin
        @(negedge clk);
        #1;
        if (mdu_start_o) starts++;
        if (halted_o || !pc_en_o) halts++;
      end
      check($sformatf("abort%0d_starts", a), 32'(starts), 32'd0);
      check($sformatf("abort%0d_stuck", a), 32'(halts), 32'd0);
      check($sformatf("abort%0d_err", a), 32'(mdu_err_o), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
